// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode constants, legal range bounds and sequencer state encoding.
package alu_pkg;

    localparam logic [4:0] OpAdd = 5'b00011;
    localparam logic [4:0] OpSub = 5'b00100;
    localparam logic [4:0] OpMul = 5'b01110;
    localparam logic [4:0] OpDiv = 5'b01111;
    localparam logic [4:0] OpNot = 5'b10001;

    localparam logic [4:0] OpFirst = OpAdd;
    localparam logic [4:0] OpLast  = OpNot;

    // Wide enough for the largest multiply/divide wait (15).
    localparam int unsigned CntW = 4;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StExec = 3'd1,
        StWbLo = 3'd2,
        StWbHi = 3'd3,
        StDone = 3'd4
    } seq_state_e;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Request, ALU and write-back signals between control unit, sequencer and ALU.
interface alu_op_sequencer_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned OPW   = 5
) ();

    logic             start;
    logic [OPW-1:0]   opcode;
    logic [WIDTH-1:0] ra_data;
    logic [WIDTH-1:0] rb_data;
    logic [WIDTH-1:0] alu_zhi;
    logic [WIDTH-1:0] alu_zlo;
    logic [OPW-1:0]   alu_opcode;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic             busy;
    logic             wb_en;
    logic             wb_hi;
    logic [WIDTH-1:0] wb_data;
    logic             done;
    logic             illegal;

    modport master (
        output start, opcode, ra_data, rb_data, alu_zhi, alu_zlo,
        input  alu_opcode, alu_a, alu_b, busy, wb_en, wb_hi, wb_data, done, illegal
    );

    modport slave (
        input  start, opcode, ra_data, rb_data, alu_zhi, alu_zlo,
        output alu_opcode, alu_a, alu_b, busy, wb_en, wb_hi, wb_data, done, illegal
    );

endinterface

// File: rtl/alu_op_class.sv
// Combinational opcode classifier: legal range check and multiply/divide detection.
module alu_op_class
    import alu_pkg::*;
#(
    parameter int unsigned OPW = 5
) (
    input  logic [OPW-1:0] opcode_i,
    output logic           legal_o,
    output logic           is_md_o
);

    always_comb begin
        legal_o = (opcode_i >= OPW'(OpFirst)) && (opcode_i <= OPW'(OpLast));
        is_md_o = legal_o && ((opcode_i == OPW'(OpMul)) || (opcode_i == OPW'(OpDiv)));
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Issue/retire controller: latches an ALU request, waits for the result, captures it and
// sequences LO (and HI for multiply/divide) register-file write-back.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned OPW     = 5,
    parameter int unsigned MD_WAIT = 4
) (
    input logic               clk,
    input logic               clr,
    alu_op_sequencer_if.slave bus
);

    seq_state_e state_q, state_d;

    logic [OPW-1:0]   op_q;
    logic [WIDTH-1:0] a_q, b_q, zhi_q, zlo_q;
    logic [CntW-1:0]  cnt_q;
    logic             md_q, illegal_q;
    logic             legal, is_md, last_exec;

    logic [OPW-1:0]   alu_opcode;
    logic             busy, wb_en, wb_hi, done;
    logic [WIDTH-1:0] wb_data;

    alu_op_class #(
        .OPW (OPW)
    ) u_class (
        .opcode_i (bus.opcode),
        .legal_o  (legal),
        .is_md_o  (is_md)
    );

    assign last_exec = (cnt_q == CntW'(1));

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (bus.start) state_d = legal ? StExec : StDone;
            StExec:  if (last_exec) state_d = StWbLo;
            StWbLo:  state_d = md_q ? StWbHi : StDone;
            StWbHi:  state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        alu_opcode = '0;
        busy       = (state_q != StIdle);
        wb_en      = 1'b0;
        wb_hi      = 1'b0;
        wb_data    = '0;
        done       = 1'b0;
        unique case (state_q)
            StExec: alu_opcode = op_q;
            StWbLo: begin
                wb_en   = 1'b1;
                wb_data = zlo_q;
            end
            StWbHi: begin
                wb_en   = 1'b1;
                wb_hi   = 1'b1;
                wb_data = zhi_q;
            end
            StDone:  done = 1'b1;
            default: ;
        endcase
    end

    // Operand, counter and result registers; the ALU result is sampled only on the final
    // EXEC edge.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            zhi_q     <= '0;
            zlo_q     <= '0;
            cnt_q     <= '0;
            md_q      <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.start && legal) begin
                        op_q  <= bus.opcode;
                        a_q   <= bus.ra_data;
                        b_q   <= bus.rb_data;
                        md_q  <= is_md;
                        cnt_q <= is_md ? CntW'(MD_WAIT) : CntW'(1);
                    end else if (bus.start) begin
                        illegal_q <= 1'b1;
                    end
                end
                StExec: begin
                    cnt_q <= cnt_q - CntW'(1);
                    if (last_exec) begin
                        zhi_q <= bus.alu_zhi;
                        zlo_q <= bus.alu_zlo;
                    end
                end
                StDone:  illegal_q <= 1'b0;
                default: ;
            endcase
        end
    end

    assign bus.alu_opcode = alu_opcode;
    assign bus.alu_a      = a_q;
    assign bus.alu_b      = b_q;
    assign bus.busy       = busy;
    assign bus.wb_en      = wb_en;
    assign bus.wb_hi      = wb_hi;
    assign bus.wb_data    = wb_data;
    assign bus.done       = done;
    assign bus.illegal    = illegal_q;

endmodule
